// File: rtl/text_line_if.sv
// Raster, config and glyph ROM bundle for the text line controller.
// master = game side / ROM, slave = controller.
interface text_line_if #(
  parameter int ADDR_W = 16
) ();
  logic              frame_start;
  logic [8:0]        row;
  logic [9:0]        col;
  logic              cfg_we;
  logic [3:0]        cfg_idx;
  logic [4:0]        cfg_char;
  logic [9:0]        cfg_x;
  logic [8:0]        cfg_y;
  logic [3:0]        cfg_len;
  logic              cfg_commit;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_q;
  logic              pixel_on;
  logic              busy;

  modport master (
    output frame_start, row, col,
    output cfg_we, cfg_idx, cfg_char,
    output cfg_x, cfg_y, cfg_len, cfg_commit,
    output rom_q,
    input  rom_addr, pixel_on, busy
  );

  modport slave (
    input  frame_start, row, col,
    input  cfg_we, cfg_idx, cfg_char,
    input  cfg_x, cfg_y, cfg_len, cfg_commit,
    input  rom_q,
    output rom_addr, pixel_on, busy
  );
endinterface

// File: rtl/text_line_controller.sv
// One line of runtime-loaded text rendered from the shared glyph ROM.
// Shadow string is committed to the active copy on a frame boundary.
module text_line_controller #(
  parameter int MAX_CHARS   = 12,
  parameter int GLYPH_W     = 50,
  parameter int GLYPH_WORDS = 2500,
  parameter int ADDR_W      = 16
) (
  input logic       clk,
  input logic       resetn,
  text_line_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, PENDING, SHOW, SHOW_PEND
  } state_t;

  localparam logic [3:0] MAXC = 4'(MAX_CHARS);
  localparam logic [5:0] GX_LAST = 6'(GLYPH_W - 1);

  state_t state, state_nx;
  logic   copy;

  logic [4:0] shadow [MAX_CHARS];
  logic [4:0] active [MAX_CHARS];
  logic [9:0] x_p, x_a;
  logic [8:0] y_p, y_a;
  logic [3:0] len_p, len_a;

  logic [5:0] gx_r, cur_gx;
  logic [3:0] slot_r, cur_slot;
  logic [10:0] col_end;
  logic [9:0]  row_end;
  logic [5:0]  gy;
  logic [4:0]  code;
  logic        render, in_row, in_col;
  logic        inbox, at_x, is_glyph;
  logic [ADDR_W-1:0] addr, addr_r;
  logic        inbox_d1, glyph_d1, pix_r;

  assign bus.busy = (state == PENDING) ||
                    (state == SHOW_PEND);
  assign bus.rom_addr = addr_r;
  assign bus.pixel_on = pix_r;

  // state register
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // next state; copy only on a frame_start without a fresh commit
  always_comb begin
    state_nx = state;
    copy     = 1'b0;
    unique case (state)
      IDLE:
        if (bus.cfg_commit) state_nx = PENDING;
      PENDING, SHOW_PEND:
        if (bus.frame_start && !bus.cfg_commit) begin
          copy     = 1'b1;
          state_nx = (len_p != 4'd0) ? SHOW : IDLE;
        end
      SHOW:
        if (bus.cfg_commit) state_nx = SHOW_PEND;
      default: state_nx = IDLE;
    endcase
  end

  // shadow writes, commit sampling and shadow->active copy
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < MAX_CHARS; i++) begin
        shadow[i] <= 5'd31;
        active[i] <= 5'd31;
      end
      x_p   <= '0;
      y_p   <= '0;
      len_p <= '0;
      x_a   <= '0;
      y_a   <= '0;
      len_a <= '0;
    end else begin
      if (copy) begin
        for (int i = 0; i < MAX_CHARS; i++)
          active[i] <= shadow[i];
        x_a   <= x_p;
        y_a   <= y_p;
        len_a <= len_p;
      end
      if (bus.cfg_we && bus.cfg_idx < MAXC)
        shadow[bus.cfg_idx] <= bus.cfg_char;
      if (bus.cfg_commit) begin
        x_p   <= bus.cfg_x;
        y_p   <= bus.cfg_y;
        len_p <= (bus.cfg_len > MAXC) ?
                 MAXC : bus.cfg_len;
      end
    end
  end

  // box test and glyph-relative position of the current pixel
  always_comb begin
    render  = (state == SHOW) || (state == SHOW_PEND);
    col_end = 11'(x_a) + 11'(len_a) * 11'(GLYPH_W);
    row_end = 10'(y_a) + 10'(GLYPH_W);
    in_row  = ({1'b0, bus.row} >= {1'b0, y_a}) &&
              ({1'b0, bus.row} < row_end) &&
              (bus.row <= 9'd479);
    in_col  = (bus.col >= x_a) &&
              ({1'b0, bus.col} < col_end) &&
              (bus.col <= 10'd639);
    inbox   = render && in_row && in_col;
    at_x    = (bus.col == x_a);
    cur_gx  = at_x ? 6'd0 : gx_r;
    cur_slot = at_x ? 4'd0 : slot_r;
    code    = (cur_slot < MAXC) ?
              active[cur_slot] : 5'd31;
    is_glyph = (code < 5'd26);
    gy      = 6'(bus.row - y_a);
    addr    = ADDR_W'(code) * ADDR_W'(GLYPH_WORDS) +
              ADDR_W'(gy) * ADDR_W'(GLYPH_W) +
              ADDR_W'(cur_gx);
  end

  // column counters: restart at origin, step while inside the box
  always_ff @(posedge clk) begin
    if (!resetn) begin
      gx_r   <= '0;
      slot_r <= '0;
    end else if (at_x || inbox) begin
      if (cur_gx == GX_LAST) begin
        gx_r   <= '0;
        slot_r <= cur_slot + 4'd1;
      end else begin
        gx_r   <= cur_gx + 6'd1;
        slot_r <= cur_slot;
      end
    end
  end

  // two-stage pipe: ROM address, then gated ROM data
  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_r   <= '0;
      inbox_d1 <= 1'b0;
      glyph_d1 <= 1'b0;
      pix_r    <= 1'b0;
    end else begin
      addr_r   <= (inbox && is_glyph) ? addr : '0;
      inbox_d1 <= inbox;
      glyph_d1 <= is_glyph;
      pix_r    <= bus.rom_q & inbox_d1 & glyph_d1;
    end
  end
endmodule
